debug_cmd_ctrl: RTL and testbench
=================================

# debug_cmd_ctrl

Debug command controller between `uart_rx` and the TX character `fifo`. It decodes single-byte host commands, steps or free-runs the MIPS pipeline through a one-cycle clock enable, and snapshots a set of 32-bit pipeline debug words. It then streams the snapshot into the TX FIFO as a framed, checksummed byte sequence, honouring FIFO backpressure.

## Interface
Parameters:
- `NUM_WORDS`, 4: number of 32-bit debug words per frame.
- `FRAME_HDR`, 8'h46 ("F"): frame header byte.
- `ERR_CHAR`, 8'h3F ("?"): reply to an unknown command.

Ports:
- `clk` in 1: single clock. All logic runs in this domain.
- `rst_n` in 1: reset, synchronous and active-low.
- `rx_data` in 8: received byte from `uart_rx`.
- `rx_data_rdy` in 1: byte-valid from `uart_rx`. A byte is accepted only on a rising edge of this signal, so a pulse or a held level each counts once.
- `dbg_words` in 32*NUM_WORDS: flattened debug words. Word k is at [32k+31:32k]; word 0 is PC.
- `fifo_full` in 1: TX FIFO full.
- `fifo_din` out 8: byte to the FIFO.
- `fifo_wr_en` out 1: FIFO write strobe. It is never asserted while `fifo_full`=1.
- `pipe_en` out 1: pipeline clock enable. Each high cycle advances the pipeline one step.
- `running` out 1: high while in free-run mode.
- `busy` out 1: high in every state except IDLE and RUN.
- `cmd_dropped` out 1: one-cycle pulse when an accepted byte is discarded.

## Operation
- Commands: "s" (0x73) = step once, then dump. "d" (0x64) = dump only. "r" (0x72) = free-run. "h" (0x68) = halt, then dump (only meaningful in RUN).
- The FSM has these states: IDLE, STEP, SNAP, HDR, DATA, CSUM, ERR, RUN.
- Transitions from IDLE on a new byte:
  - "s" goes to STEP.
  - "d" goes to SNAP.
  - "r" goes to RUN.
  - "h" is ignored; it stays in IDLE and pulses `cmd_dropped`.
  - Any other byte goes to ERR.
- STEP: `pipe_en`=1 for exactly one cycle, then SNAP.
- SNAP: registers all of `dbg_words` into the snapshot, clears the checksum, then goes to HDR.
- HDR: presents `FRAME_HDR` and goes to DATA once it is written.
- DATA: sends 4*NUM_WORDS bytes, word 0 first and LSB first within each word. Each written byte is XORed into the 8-bit checksum. After the last byte it goes to CSUM.
- CSUM: presents the checksum, then returns to IDLE.
- ERR: writes `ERR_CHAR` once, then returns to IDLE.
- RUN: `pipe_en`=1 and `running`=1 every cycle.
  - "h" leaves RUN for SNAP; `pipe_en` is already 0 in the SNAP cycle.
  - Any other byte in RUN is ignored and pulses `cmd_dropped`.
- Backpressure: in HDR, DATA, CSUM and ERR, `fifo_wr_en` = !`fifo_full`. `fifo_din` holds its byte, and the byte counter advances only on a write.
- Busy drop: a byte arriving while `busy`=1 is discarded with a `cmd_dropped` pulse, and the FSM is unaffected.
- Snapshot stability: the snapshot is frozen from SNAP until CSUM is done. `dbg_words` changes during that window do not alter the frame.
- Frame length: 4*NUM_WORDS+2 bytes (18 at the default).

## Timing
- Reset values: `fifo_din`=0, `fifo_wr_en`=0, `pipe_en`=0, `running`=0, `busy`=0, `cmd_dropped`=0. State = IDLE, counters = 0, edge detector primed low.
- Reset mid-frame or mid-run: in the next cycle the FSM is IDLE, no further FIFO writes occur, and the partial frame is abandoned.
- Output style: Moore outputs, decoded from registered state and counters.
- Byte acceptance: the rising edge of `rx_data_rdy` is sampled in cycle T. The decoded state is effective in T+1.
- "s" with no backpressure:
  - STEP in T+1 (`pipe_en` high).
  - SNAP in T+2.
  - HDR write in T+3.
  - Data writes in T+4..T+19.
  - CSUM write in T+20.
  - IDLE in T+21.
- "d" with no backpressure: same sequence with STEP removed, so the last write is in T+19.
- Each cycle with `fifo_full`=1 stalls the sequence by exactly one cycle.
- Byte counter: 5 bits for the default. It wraps to 0 on entering CSUM.

## Structure
- Shared package `dbg_pkg` holds:
  - the command byte constants (`CMD_STEP`, `CMD_DUMP`, `CMD_RUN`, `CMD_HALT`);
  - the `FRAME_HDR` and `ERR_CHAR` defaults;
  - the FSM state encoding.
- Sub-module `dbg_frame_ser` is the natural split. It holds the snapshot register, byte/word counter, XOR checksum and backpressure-aware write logic. It starts on `start` and reports `done`.
- The command decode, RUN and STEP handling, and the edge detector stay in the top module.

## Test plan
- Step: `dbg_words`={0,0,0,0x11223344} is applied with word0=0x11223344, and "s" is sent with FIFO never full. Expected: one `pipe_en` cycle at T+1, then 18 writes 46 44 33 22 11 00×12 44, and `busy` low at T+21.
- Backpressure: "d" is sent and `fifo_full` is forced high for 3 cycles during DATA byte 5. Expected: no `fifo_wr_en` during the full cycles, no byte lost or duplicated, and the frame completes 3 cycles later than the unstalled case.
- Run/halt: "r" is sent, 20 cycles pass, then "h" is sent. Expected: `running`=1 and `pipe_en`=1 for every RUN cycle; "x" received during RUN pulses `cmd_dropped`; after "h" a full frame is emitted with the snapshot taken in SNAP.
- Unknown and busy: "z" in IDLE. Expected: a single 0x3F write. Then "s" followed by "d" 3 cycles later. Expected: "d" is dropped with `cmd_dropped`=1 and exactly one frame is produced.
- Level-held ready: `rx_data_rdy` is held high for 10 cycles with "d". Expected: exactly one frame.
- Reset: `rst_n` low at DATA byte 7. Expected: the next cycle shows IDLE with all outputs at their reset values; a later "d" produces a complete, correct frame.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared constants and FSM encoding for the debug command controller.
package dbg_pkg;

   localparam logic [7:0] CMD_STEP = 8'h73;
   localparam logic [7:0] CMD_DUMP = 8'h64;
   localparam logic [7:0] CMD_RUN  = 8'h72;
   localparam logic [7:0] CMD_HALT = 8'h68;

   localparam logic [7:0] FRAME_HDR_DEF = 8'h46;
   localparam logic [7:0] ERR_CHAR_DEF  = 8'h3F;

   typedef enum logic [2:0] {
      StIdle,
      StStep,
      StSnap,
      StHdr,
      StData,
      StCsum,
      StErr,
      StRun
   } dbg_state_e;

endpackage

// File: rtl/dbg_frame_ser.sv
// Snapshot register, byte counter, XOR checksum and FIFO write logic for one debug frame.
module dbg_frame_ser
   import dbg_pkg::*;
#(
   parameter int unsigned NUM_WORDS = 4,
   parameter logic [7:0]  FRAME_HDR = FRAME_HDR_DEF,
   parameter logic [7:0]  ERR_CHAR  = ERR_CHAR_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  dbg_state_e              state,
   input  logic [32*NUM_WORDS-1:0] dbg_words,
   input  logic                    fifo_full,
   output logic [7:0]              fifo_din,
   output logic                    fifo_wr_en,
   output logic                    last_byte,
   output logic                    done
);

   localparam int unsigned NumBytes = 4 * NUM_WORDS;
   localparam int unsigned IdxW     = $clog2(NumBytes);
   localparam int unsigned CntW     = IdxW + 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(NumBytes - 1);

   logic [7:0]      snap_q [NumBytes];
   logic [7:0]      snap_d [NumBytes];
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [7:0]      csum_q, csum_d;
   logic            write_state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < NumBytes; k++) begin
            snap_q[k] <= '0;
         end
         cnt_q  <= '0;
         csum_q <= '0;
      end else begin
         snap_q <= snap_d;
         cnt_q  <= cnt_d;
         csum_q <= csum_d;
      end
   end

   assign last_byte   = (cnt_q == LastCnt);
   assign write_state = (state == StHdr) || (state == StData) || (state == StCsum) ||
                        (state == StErr);
   assign fifo_wr_en  = write_state && !fifo_full;
   assign done        = (state == StCsum) && fifo_wr_en;

   always_comb begin
      snap_d = snap_q;
      cnt_d  = cnt_q;
      csum_d = csum_q;
      if (start) begin
         for (int k = 0; k < NumBytes; k++) begin
            snap_d[k] = dbg_words[8*k +: 8];
         end
         cnt_d  = '0;
         csum_d = '0;
      end else if ((state == StData) && fifo_wr_en) begin
         // Counter only moves on an actual write, so a stall re-presents the same byte.
         csum_d = csum_q ^ snap_q[cnt_q[IdxW-1:0]];
         cnt_d  = last_byte ? '0 : cnt_q + 1'b1;
      end
   end

   always_comb begin
      fifo_din = '0;
      case (state)
         StHdr:   fifo_din = FRAME_HDR;
         StData:  fifo_din = snap_q[cnt_q[IdxW-1:0]];
         StCsum:  fifo_din = csum_q;
         StErr:   fifo_din = ERR_CHAR;
         default: fifo_din = '0;
      endcase
   end

endmodule

// File: rtl/debug_cmd_ctrl.sv
// Host command decoder: steps or free-runs the pipeline and streams framed debug snapshots.
module debug_cmd_ctrl
   import dbg_pkg::*;
#(
   parameter int unsigned NUM_WORDS = 4,
   parameter logic [7:0]  FRAME_HDR = FRAME_HDR_DEF,
   parameter logic [7:0]  ERR_CHAR  = ERR_CHAR_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7:0]              rx_data,
   input  logic                    rx_data_rdy,
   input  logic [32*NUM_WORDS-1:0] dbg_words,
   input  logic                    fifo_full,
   output logic [7:0]              fifo_din,
   output logic                    fifo_wr_en,
   output logic                    pipe_en,
   output logic                    running,
   output logic                    busy,
   output logic                    cmd_dropped
);

   dbg_state_e state_q, state_d;
   logic       rdy_q;
   logic       drop_q, drop_d;
   logic       rx_rise;
   logic       snap_start;
   logic       ser_last;
   logic       ser_done;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         rdy_q   <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rdy_q   <= rx_data_rdy;
         drop_q  <= drop_d;
      end
   end

   assign rx_rise     = rx_data_rdy && !rdy_q;
   assign busy        = (state_q != StIdle) && (state_q != StRun);
   assign pipe_en     = (state_q == StStep) || (state_q == StRun);
   assign running     = (state_q == StRun);
   assign cmd_dropped = drop_q;
   assign snap_start  = (state_q == StSnap);

   always_comb begin
      state_d = state_q;
      drop_d  = 1'b0;
      case (state_q)
         StIdle: begin
            if (rx_rise) begin
               case (rx_data)
                  CMD_STEP: state_d = StStep;
                  CMD_DUMP: state_d = StSnap;
                  CMD_RUN:  state_d = StRun;
                  CMD_HALT: drop_d  = 1'b1;
                  default:  state_d = StErr;
               endcase
            end
         end
         StStep: state_d = StSnap;
         StSnap: state_d = StHdr;
         StHdr:  if (fifo_wr_en) state_d = StData;
         StData: if (fifo_wr_en && ser_last) state_d = StCsum;
         StCsum: if (ser_done) state_d = StIdle;
         StErr:  if (fifo_wr_en) state_d = StIdle;
         StRun: begin
            if (rx_rise) begin
               if (rx_data == CMD_HALT) begin
                  state_d = StSnap;
               end else begin
                  drop_d = 1'b1;
               end
            end
         end
      endcase
      if (rx_rise && busy) begin
         drop_d = 1'b1;
      end
   end

   dbg_frame_ser #(
      .NUM_WORDS (NUM_WORDS),
      .FRAME_HDR (FRAME_HDR),
      .ERR_CHAR  (ERR_CHAR)
   ) u_frame_ser (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (snap_start),
      .state      (state_q),
      .dbg_words  (dbg_words),
      .fifo_full  (fifo_full),
      .fifo_din   (fifo_din),
      .fifo_wr_en (fifo_wr_en),
      .last_byte  (ser_last),
      .done       (ser_done)
   );

endmodule

// File: tb/tb_debug_cmd_ctrl.sv
// Scoreboarded bench for debug_cmd_ctrl: frames, timing, backpressure, drops and reset.
module tb_debug_cmd_ctrl;
   import dbg_pkg::*;

   localparam int unsigned NW = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [7:0]        rx_data = '0;
   logic              rx_data_rdy = 1'b0;
   logic [32*NW-1:0]  dbg_words = '0;
   logic              fifo_full = 1'b0;
   logic [7:0]        fifo_din;
   logic              fifo_wr_en;
   logic              pipe_en;
   logic              running;
   logic              busy;
   logic              cmd_dropped;

   int                checks = 0;
   int                passes = 0;
   logic [7:0]        exp_q[$];
   logic [7:0]        mon_exp;

   always #5 clk = ~clk;

   debug_cmd_ctrl #(
      .NUM_WORDS (NW),
      .FRAME_HDR (8'h46),
      .ERR_CHAR  (8'h3F)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_data     (rx_data),
      .rx_data_rdy (rx_data_rdy),
      .dbg_words   (dbg_words),
      .fifo_full   (fifo_full),
      .fifo_din    (fifo_din),
      .fifo_wr_en  (fifo_wr_en),
      .pipe_en     (pipe_en),
      .running     (running),
      .busy        (busy),
      .cmd_dropped (cmd_dropped)
   );

   // Scoreboard: every FIFO write is popped against the expected byte stream.
   always @(negedge clk) begin
      if (fifo_wr_en === 1'b1) begin
         checks++;
         if (fifo_full !== 1'b0) $display("FAIL wr_while_full got full=%b required 0", fifo_full);
         else passes++;
         checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL fifo_byte got %02h required no write", fifo_din);
         end else begin
            mon_exp = exp_q.pop_front();
            if (fifo_din !== mon_exp) $display("FAIL fifo_byte got %02h required %02h",
                                               fifo_din, mon_exp);
            else passes++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input logic [32*NW-1:0] w);
      logic [7:0] b;
      logic [7:0] cs;
      cs = 8'h00;
      exp_q.push_back(8'h46);
      for (int k = 0; k < 4*NW; k++) begin
         b = w[8*k +: 8];
         cs = cs ^ b;
         exp_q.push_back(b);
      end
      exp_q.push_back(cs);
   endtask

   // Drives a one-cycle ready pulse; returns at the start of the cycle after acceptance.
   task automatic send_byte(input logic [7:0] b);
      tick();
      rx_data = b;
      rx_data_rdy = 1'b1;
      tick();
      rx_data_rdy = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) break;
         tick();
      end
      checks++;
      if (busy !== 1'b0) $display("FAIL %s_timeout got busy=%b required 0", name, busy);
      else passes++;
      tick();
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (exp_q.size() != 0) $display("FAIL %s_drained got %0d bytes pending required 0",
                                      name, exp_q.size());
      else passes++;
   endtask

   task automatic test_reset();
      logic [12:0] obs;
      rst_n = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      obs = {fifo_din, fifo_wr_en, pipe_en, running, busy, cmd_dropped};
      checks++;
      if (obs !== 13'h0) $display("FAIL reset_outputs got %04h required 0000", obs);
      else passes++;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_step();
      logic [31:0] wr_mask, pe_mask, exp_wr, exp_pe;
      logic        busy_end;
      wr_mask = '0; pe_mask = '0; exp_wr = '0; exp_pe = '0; busy_end = 1'b1;
      dbg_words = {32'h0, 32'h0, 32'h0, 32'h1122_3344};
      push_frame(dbg_words);
      send_byte(CMD_STEP);
      for (int i = 1; i <= 21; i++) begin
         @(negedge clk);
         wr_mask[i] = fifo_wr_en;
         pe_mask[i] = pipe_en;
         exp_wr[i]  = (i >= 3) && (i <= 20);
         exp_pe[i]  = (i == 1);
         if (i == 21) busy_end = busy;
         tick();
      end
      checks++;
      if (pe_mask !== exp_pe) $display("FAIL step_pipe_en got %08h required %08h",
                                       pe_mask, exp_pe);
      else passes++;
      checks++;
      if (wr_mask !== exp_wr) $display("FAIL step_write_cycles got %08h required %08h",
                                       wr_mask, exp_wr);
      else passes++;
      checks++;
      if (busy_end !== 1'b0) $display("FAIL step_busy_end got %b required 0", busy_end);
      else passes++;
      check_drained("step");
   endtask

   task automatic test_backpressure();
      logic [31:0] wr_mask, exp_wr;
      logic        busy_end;
      wr_mask = '0; exp_wr = '0; busy_end = 1'b1;
      dbg_words = {32'hdead_beef, 32'h0123_4567, 32'h89ab_cdef, 32'hcafe_f00d};
      push_frame(dbg_words);
      send_byte(CMD_DUMP);
      for (int i = 1; i <= 23; i++) begin
         fifo_full = (i >= 8) && (i <= 10);
         // Snapshot is already frozen; this must not leak into the frame.
         if (i == 5) dbg_words = {4{32'h5a5a_a5a5}};
         @(negedge clk);
         wr_mask[i] = fifo_wr_en;
         exp_wr[i]  = ((i >= 2) && (i <= 7)) || ((i >= 11) && (i <= 22));
         if (i == 23) busy_end = busy;
         tick();
      end
      fifo_full = 1'b0;
      checks++;
      if (wr_mask !== exp_wr) $display("FAIL bp_write_cycles got %08h required %08h",
                                       wr_mask, exp_wr);
      else passes++;
      checks++;
      if (busy_end !== 1'b0) $display("FAIL bp_busy_end got %b required 0", busy_end);
      else passes++;
      check_drained("bp");
   endtask

   task automatic test_run_halt();
      int         run_ok;
      logic [1:0] drop_obs;
      logic [2:0] snap_obs;
      logic [32*NW-1:0] w;
      run_ok = 0;
      send_byte(CMD_RUN);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (running && pipe_en) run_ok++;
         tick();
      end
      send_byte(8'h78);
      @(negedge clk);
      drop_obs = {cmd_dropped, running};
      checks++;
      if (drop_obs !== 2'b11) $display("FAIL run_drop got %b required 11", drop_obs);
      else passes++;
      tick();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (running && pipe_en) run_ok++;
         tick();
      end
      checks++;
      if (run_ok != 18) $display("FAIL run_cycles got %0d required 18", run_ok);
      else passes++;
      w = {32'h0bad_f00d, 32'h7654_3210, 32'hfeed_face, 32'h0040_0010};
      dbg_words = w;
      push_frame(w);
      send_byte(CMD_HALT);
      @(negedge clk);
      snap_obs = {pipe_en, running, busy};
      checks++;
      if (snap_obs !== 3'b001) $display("FAIL halt_snap got %b required 001", snap_obs);
      else passes++;
      tick();
      dbg_words = ~w;
      wait_idle("halt");
      check_drained("halt");
   endtask

   task automatic test_unknown_busy();
      exp_q.push_back(8'h3F);
      send_byte(8'h7A);
      wait_idle("err");
      check_drained("err");
      dbg_words = {32'h1, 32'h2, 32'h3, 32'h4};
      push_frame(dbg_words);
      send_byte(CMD_STEP);
      tick();
      send_byte(CMD_DUMP);
      @(negedge clk);
      checks++;
      if (cmd_dropped !== 1'b1) $display("FAIL busy_drop got %b required 1", cmd_dropped);
      else passes++;
      tick();
      wait_idle("busy");
      repeat (25) tick();
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) $display("FAIL busy_single_frame got busy=%b required 0", busy);
      else passes++;
      tick();
      check_drained("busy");
   endtask

   task automatic test_level_held();
      dbg_words = {32'h1357_9bdf, 32'h2468_ace0, 32'h0f0f_0f0f, 32'hf0f0_f0f0};
      push_frame(dbg_words);
      rx_data = CMD_DUMP;
      rx_data_rdy = 1'b1;
      repeat (10) tick();
      rx_data_rdy = 1'b0;
      wait_idle("level");
      repeat (25) tick();
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) $display("FAIL level_single_frame got busy=%b required 0", busy);
      else passes++;
      tick();
      check_drained("level");
   endtask

   task automatic test_mid_reset();
      logic [12:0] obs;
      dbg_words = {32'haaaa_5555, 32'h3333_cccc, 32'h9999_6666, 32'h1234_abcd};
      push_frame(dbg_words);
      send_byte(CMD_DUMP);
      repeat (9) tick();
      rst_n = 1'b0;
      tick();
      checks++;
      if (exp_q.size() != 9) $display("FAIL rst_partial got %0d pending required 9",
                                      exp_q.size());
      else passes++;
      exp_q.delete();
      @(negedge clk);
      obs = {fifo_din, fifo_wr_en, pipe_en, running, busy, cmd_dropped};
      checks++;
      if (obs !== 13'h0) $display("FAIL rst_mid_outputs got %04h required 0000", obs);
      else passes++;
      tick();
      rst_n = 1'b1;
      repeat (5) tick();
      dbg_words = {32'hc001_d00d, 32'h0, 32'hffff_ffff, 32'h8000_0001};
      push_frame(dbg_words);
      send_byte(CMD_DUMP);
      wait_idle("rst_after");
      check_drained("rst_after");
   endtask

   initial begin
      test_reset();
      test_step();
      test_backpressure();
      test_run_halt();
      test_unknown_busy();
      test_level_held();
      test_mid_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
